// File: rtl/timer_pkg.sv
// Shared constants and helpers for the multi-channel APB timer.
// Holds the register offsets, control/status bit positions and the tick decode.
package timer_pkg;

   localparam logic [2:0] OFF_TDR  = 3'd0;
   localparam logic [2:0] OFF_TCR  = 3'd1;
   localparam logic [2:0] OFF_TSR  = 3'd2;
   localparam logic [2:0] OFF_TIER = 3'd3;
   localparam logic [2:0] OFF_TCNT = 3'd4;

   localparam int LOAD = 7;
   localparam int ARL  = 6;
   localparam int DN   = 5;
   localparam int EN   = 4;

   localparam int OVF  = 0;
   localparam int UDF  = 1;

   localparam int CH_STRIDE = 8;

   // True on the edge where prescaler bit cks falls from 1 to 0.
   function automatic logic presc_tick(input logic [3:0] presc, input logic [1:0] cks);
      logic r;
      case (cks)
         2'd0:    r = presc[0];
         2'd1:    r = &presc[1:0];
         2'd2:    r = &presc[2:0];
         2'd3:    r = &presc[3:0];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/timer_ch.sv
// One timer channel: TDR/TCR/TSR/TIER/TCNT registers, up/down counter,
// sticky overflow/underflow flags and a registered level interrupt.
module timer_ch
   import timer_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_pclk,
   input  logic             i_presetn,
   input  logic [3:0]       i_presc,
   input  logic             i_we,
   input  logic [2:0]       i_off,
   input  logic [CNT_W-1:0] i_wdata,
   output logic [CNT_W-1:0] o_rdata,
   output logic             o_irq_nxt,
   output logic             o_irq
);

   logic [CNT_W-1:0] r_tdr;
   logic [7:0]       r_tcr;
   logic [1:0]       r_tsr;
   logic [1:0]       r_tier;
   logic [CNT_W-1:0] r_tcnt;
   logic             r_irq;

   logic             w_tick;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_ovf_set;
   logic             w_udf_set;
   logic [1:0]       w_set;
   logic [1:0]       w_tsr_nxt;
   logic [CNT_W-1:0] w_rdata;
   logic             w_irq_nxt;

   // Counter next-state: load dominates, then a counting tick with wrap/reload.
   always_comb begin
      w_tick    = presc_tick(i_presc, r_tcr[1:0]);
      w_cnt_nxt = r_tcnt;
      w_ovf_set = 1'b0;
      w_udf_set = 1'b0;
      if (r_tcr[LOAD]) begin
         w_cnt_nxt = r_tdr;
      end else if (r_tcr[EN] && w_tick) begin
         if (!r_tcr[DN]) begin
            if (r_tcnt == {CNT_W{1'b1}}) begin
               w_cnt_nxt = r_tcr[ARL] ? r_tdr : {CNT_W{1'b0}};
               w_ovf_set = 1'b1;
            end else begin
               w_cnt_nxt = r_tcnt + CNT_W'(1'b1);
            end
         end else begin
            if (r_tcnt == {CNT_W{1'b0}}) begin
               w_cnt_nxt = r_tcr[ARL] ? r_tdr : {CNT_W{1'b1}};
               w_udf_set = 1'b1;
            end else begin
               w_cnt_nxt = r_tcnt - CNT_W'(1'b1);
            end
         end
      end else begin
         w_cnt_nxt = r_tcnt;
      end
   end

   // Status next-state: write-0-to-clear, a hardware set in the same cycle wins.
   always_comb begin
      w_set      = 2'b00;
      w_set[OVF] = w_ovf_set;
      w_set[UDF] = w_udf_set;
      if (i_we && (i_off == OFF_TSR)) begin
         w_tsr_nxt = (r_tsr & i_wdata[1:0]) | w_set;
      end else begin
         w_tsr_nxt = r_tsr | w_set;
      end
   end

   // Register read-back for this channel, selected by offset.
   always_comb begin
      case (i_off)
         OFF_TDR:  w_rdata = r_tdr;
         OFF_TCR:  w_rdata = CNT_W'(r_tcr);
         OFF_TSR:  w_rdata = CNT_W'(r_tsr);
         OFF_TIER: w_rdata = CNT_W'(r_tier);
         OFF_TCNT: w_rdata = r_tcnt;
         default:  w_rdata = {CNT_W{1'b0}};
      endcase
   end

   assign w_irq_nxt = |(r_tsr & r_tier);

   // Channel state registers.
   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_tdr  <= {CNT_W{1'b0}};
         r_tcr  <= 8'h00;
         r_tsr  <= 2'b00;
         r_tier <= 2'b00;
         r_tcnt <= {CNT_W{1'b0}};
         r_irq  <= 1'b0;
      end else begin
         if (i_we && (i_off == OFF_TDR)) begin
            r_tdr <= i_wdata;
         end
         if (i_we && (i_off == OFF_TCR)) begin
            r_tcr <= i_wdata[7:0] & 8'hF3;
         end
         if (i_we && (i_off == OFF_TIER)) begin
            r_tier <= i_wdata[1:0];
         end
         r_tsr  <= w_tsr_nxt;
         r_tcnt <= w_cnt_nxt;
         r_irq  <= w_irq_nxt;
      end
   end

   assign o_rdata   = w_rdata;
   assign o_irq_nxt = w_irq_nxt;
   assign o_irq     = r_irq;

endmodule

// File: rtl/timer_multi_ch.sv
// N-channel APB timer: address decode, read mux, shared prescaler and irq_any,
// with the per-channel state held in timer_ch instances.
module timer_multi_ch
   import timer_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              i_pclk,
   input  logic              i_presetn,
   input  logic              i_psel,
   input  logic              i_penable,
   input  logic              i_pwrite,
   input  logic [ADDR_W-1:0] i_paddr,
   input  logic [CNT_W-1:0]  i_pwdata,
   output logic [CNT_W-1:0]  o_prdata,
   output logic              o_pready,
   output logic              o_pslverr,
   output logic [NUM_CH-1:0] o_irq,
   output logic              o_irq_any
);

   logic [3:0]        r_presc;
   logic              r_irq_any;

   logic [31:0]       w_idx;
   logic [2:0]        w_off;
   logic              w_access;
   logic              w_err;
   logic              w_wr;
   logic [NUM_CH-1:0] w_we;
   logic [NUM_CH-1:0] w_irq_nxt;
   logic [CNT_W-1:0]  w_ch_rdata [NUM_CH];
   logic [CNT_W-1:0]  w_rdata;

   assign w_idx    = 32'(i_paddr[ADDR_W-1:3]);
   assign w_off    = i_paddr[2:0];
   assign w_access = i_psel & i_penable;
   // Any slave error also blocks the write, so an erroring access changes nothing.
   assign w_err    = w_access & ((w_idx >= 32'(NUM_CH)) | (w_off > OFF_TCNT) |
                                 (i_pwrite & (w_off == OFF_TCNT)));
   assign w_wr     = w_access & i_pwrite & ~w_err;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_we[g] = w_wr & (w_idx == 32'(g));

      timer_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .i_pclk    (i_pclk),
         .i_presetn (i_presetn),
         .i_presc   (r_presc),
         .i_we      (w_we[g]),
         .i_off     (w_off),
         .i_wdata   (i_pwdata),
         .o_rdata   (w_ch_rdata[g]),
         .o_irq_nxt (w_irq_nxt[g]),
         .o_irq     (o_irq[g])
      );
   end

   // Read data is driven only during a legal read access phase.
   always_comb begin
      w_rdata = {CNT_W{1'b0}};
      if (w_access && !i_pwrite && !w_err) begin
         for (int c = 0; c < NUM_CH; c++) begin
            w_rdata = (w_idx == 32'(c)) ? w_ch_rdata[c] : w_rdata;
         end
      end else begin
         w_rdata = {CNT_W{1'b0}};
      end
   end

   // Shared free-running prescaler and the aggregate interrupt register.
   always_ff @(posedge i_pclk or negedge i_presetn) begin
      if (!i_presetn) begin
         r_presc   <= 4'd0;
         r_irq_any <= 1'b0;
      end else begin
         r_presc   <= r_presc + 4'd1;
         r_irq_any <= |w_irq_nxt;
      end
   end

   assign o_prdata  = w_rdata;
   assign o_pready  = 1'b1;
   assign o_pslverr = w_err;
   assign o_irq_any = r_irq_any;

endmodule

// File: tb/tb_timer_multi_ch.sv
// Randomised and directed bench for timer_multi_ch against a cycle-level
// behavioural model of the register map, prescaler, counters and interrupts.
module tb_timer_multi_ch;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int ADDR_W = 8;
   localparam int MAXV   = 255;

   logic              i_pclk;
   logic              i_presetn;
   logic              i_psel;
   logic              i_penable;
   logic              i_pwrite;
   logic [ADDR_W-1:0] i_paddr;
   logic [CNT_W-1:0]  i_pwdata;
   logic [CNT_W-1:0]  o_prdata;
   logic              o_pready;
   logic              o_pslverr;
   logic [NUM_CH-1:0] o_irq;
   logic              o_irq_any;

   int n_chk;
   int n_err;

   int m_tdr  [NUM_CH];
   int m_tcr  [NUM_CH];
   int m_tsr  [NUM_CH];
   int m_tier [NUM_CH];
   int m_tcnt [NUM_CH];
   logic [NUM_CH-1:0] m_irq;
   logic              m_any;
   int                m_presc;

   timer_multi_ch #(
      .NUM_CH(NUM_CH),
      .CNT_W (CNT_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .i_pclk    (i_pclk),
      .i_presetn (i_presetn),
      .i_psel    (i_psel),
      .i_penable (i_penable),
      .i_pwrite  (i_pwrite),
      .i_paddr   (i_paddr),
      .i_pwdata  (i_pwdata),
      .o_prdata  (o_prdata),
      .o_pready  (o_pready),
      .o_pslverr (o_pslverr),
      .o_irq     (o_irq),
      .o_irq_any (o_irq_any)
   );

   initial i_pclk = 1'b0;
   always #5 i_pclk = ~i_pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_tdr[c]  = 0;
         m_tcr[c]  = 0;
         m_tsr[c]  = 0;
         m_tier[c] = 0;
         m_tcnt[c] = 0;
      end
      m_irq   = '0;
      m_any   = 1'b0;
      m_presc = 0;
   endtask

   function automatic bit m_err(input int addr, input bit wr);
      int idx;
      int off;
      idx = addr / 8;
      off = addr % 8;
      return (idx >= NUM_CH) || (off > 4) || (wr && (off == 4));
   endfunction

   function automatic int m_read(input int addr);
      int idx;
      int off;
      idx = addr / 8;
      off = addr % 8;
      if (m_err(addr, 1'b0)) return 0;
      case (off)
         0:       return m_tdr[idx];
         1:       return m_tcr[idx];
         2:       return m_tsr[idx];
         3:       return m_tier[idx];
         4:       return m_tcnt[idx];
         default: return 0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      int  a;
      int  widx;
      int  woff;
      int  wd;
      bit  wr;
      bit  tick;
      int  period;
      int  ncnt [NUM_CH];
      int  nsr  [NUM_CH];
      logic [NUM_CH-1:0] nirq;
      if (!i_presetn) begin
         model_reset();
         return;
      end
      a    = int'(i_paddr);
      widx = a / 8;
      woff = a % 8;
      wd   = int'(i_pwdata);
      wr   = i_psel && i_penable && i_pwrite && !m_err(a, 1'b1);
      for (int c = 0; c < NUM_CH; c++) begin
         int sets;
         nirq[c] = (m_tsr[c] & m_tier[c]) != 0;
         period  = 2 << (m_tcr[c] & 3);
         tick    = ((m_presc + 1) % period) == 0;
         sets    = 0;
         ncnt[c] = m_tcnt[c];
         if (m_tcr[c][7]) begin
            ncnt[c] = m_tdr[c];
         end else if (m_tcr[c][4] && tick) begin
            if (!m_tcr[c][5]) begin
               if (m_tcnt[c] == MAXV) begin
                  ncnt[c] = m_tcr[c][6] ? m_tdr[c] : 0;
                  sets    = 1;
               end else begin
                  ncnt[c] = m_tcnt[c] + 1;
               end
            end else begin
               if (m_tcnt[c] == 0) begin
                  ncnt[c] = m_tcr[c][6] ? m_tdr[c] : MAXV;
                  sets    = 2;
               end else begin
                  ncnt[c] = m_tcnt[c] - 1;
               end
            end
         end
         nsr[c] = m_tsr[c];
         if (wr && widx == c && woff == 2) nsr[c] = m_tsr[c] & wd & 3;
         nsr[c] = nsr[c] | sets;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         m_tcnt[c] = ncnt[c];
         m_tsr[c]  = nsr[c];
         if (wr && widx == c) begin
            if (woff == 0) m_tdr[c]  = wd;
            if (woff == 1) m_tcr[c]  = wd & 'hF3;
            if (woff == 3) m_tier[c] = wd & 3;
         end
      end
      m_irq   = nirq;
      m_any   = |nirq;
      m_presc = (m_presc + 1) % 16;
   endtask

   task automatic cyc();
      model_edge();
      @(posedge i_pclk);
      #1;
      chk("irq", 32'(o_irq), 32'(m_irq));
      chk("irq_any", 32'(o_irq_any), 32'(m_any));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic apb_write(input int addr, input int data);
      i_paddr   = ADDR_W'(addr);
      i_pwdata  = CNT_W'(data);
      i_pwrite  = 1'b1;
      i_psel    = 1'b1;
      i_penable = 1'b0;
      cyc();
      i_penable = 1'b1;
      #1;
      chk("wr_slverr", 32'(o_pslverr), 32'(m_err(addr, 1'b1)));
      chk("pready", 32'(o_pready), 32'd1);
      cyc();
      i_psel    = 1'b0;
      i_penable = 1'b0;
      i_pwrite  = 1'b0;
   endtask

   task automatic apb_read(input int addr, output int val, output int err);
      i_paddr   = ADDR_W'(addr);
      i_pwrite  = 1'b0;
      i_psel    = 1'b1;
      i_penable = 1'b0;
      cyc();
      i_penable = 1'b1;
      #1;
      val = int'(o_prdata);
      err = int'(o_pslverr);
      chk("rd_data", 32'(o_prdata), 32'(m_read(addr)));
      chk("rd_slverr", 32'(o_pslverr), 32'(m_err(addr, 1'b0)));
      cyc();
      i_psel    = 1'b0;
      i_penable = 1'b0;
   endtask

   task automatic rd_expect(input string tag, input int addr, input int exp);
      int v;
      int e;
      apb_read(addr, v, e);
      chk(tag, 32'(v), 32'(exp));
   endtask

   task automatic wait_presc(input int target);
      int n;
      n = 0;
      while (m_presc != target && n < 20) begin
         cyc();
         n++;
      end
      chk("presc_wait_bound", 32'(m_presc), 32'(target));
   endtask

   task automatic check_all_zero();
      for (int c = 0; c < NUM_CH; c++) begin
         for (int o = 0; o < 5; o++) rd_expect("reset_reg", c * 8 + o, 0);
      end
   endtask

   task automatic do_reset();
      i_presetn = 1'b0;
      #2;
      model_reset();
      chk("rst_irq", 32'(o_irq), 32'd0);
      chk("rst_irq_any", 32'(o_irq_any), 32'd0);
      chk("rst_slverr", 32'(o_pslverr), 32'd0);
      chk("rst_prdata", 32'(o_prdata), 32'd0);
      repeat (2) @(posedge i_pclk);
      #1;
      i_presetn = 1'b1;
   endtask

   initial begin
      int v;
      int e;
      n_chk     = 0;
      n_err     = 0;
      i_presetn = 1'b0;
      i_psel    = 1'b0;
      i_penable = 1'b0;
      i_pwrite  = 1'b0;
      i_paddr   = '0;
      i_pwdata  = '0;
      model_reset();
      #3;
      do_reset();
      check_all_zero();

      // ch0 up overflow with interrupt
      apb_write(0, 'hFE);
      apb_write(1, 'h80);
      apb_write(1, 'h10);
      apb_write(3, 'h01);
      idle(20);
      rd_expect("ch0_ovf", 2, 'h01);
      chk("ch0_irq", 32'(o_irq[0]), 32'd1);
      rd_expect("ch0_tcr", 1, 'h10);

      // ch1 down, disabled then enabled
      apb_write(8, 'h00);
      apb_write(9, 'h80);
      apb_write(9, 'h20);
      idle(50);
      rd_expect("ch1_hold_cnt", 12, 'h00);
      rd_expect("ch1_hold_tsr", 10, 'h00);
      apb_write(9, 'h30);
      idle(2);
      rd_expect("ch1_udf", 10, 'h02);
      apb_write(9, 'h00);

      // ch2 auto-reload
      apb_write(16, 'hF0);
      apb_write(17, 'h80);
      apb_write(17, 'h51);
      idle(70);
      rd_expect("ch2_ovf", 18, 'h01);
      apb_read(20, v, e);

      // flags on ch1: both set, then clear only ovf
      apb_write(8, 'hFF);
      apb_write(9, 'h80);
      apb_write(9, 'h10);
      idle(4);
      apb_write(9, 'h00);
      rd_expect("ch1_both", 10, 'h03);
      apb_write(10, 'h02);
      rd_expect("ch1_clr_ovf", 10, 'h02);

      // clear coinciding with an overflow tick: set wins
      apb_write(9, 'h80);
      apb_write(9, 'h53);
      wait_presc(14);
      apb_write(10, 'h00);
      rd_expect("set_wins", 10, 'h01);
      wait_presc(2);
      apb_write(10, 'h00);
      rd_expect("clear_ok", 10, 'h00);
      apb_write(9, 'h00);

      // irq clear on ch1
      apb_write(11, 'h03);
      apb_write(9, 'h80);
      apb_write(9, 'h10);
      idle(4);
      apb_write(9, 'h00);
      chk("ch1_irq_on", 32'(o_irq[1]), 32'd1);
      apb_write(10, 'h00);
      idle(1);
      chk("ch1_irq_off", 32'(o_irq[1]), 32'd0);

      // decode errors
      apb_write(4, 'h55);
      apb_read(4, v, e);
      apb_read(NUM_CH * 8, v, e);
      chk("oob_slverr", 32'(e), 32'd1);
      chk("oob_prdata", 32'(v), 32'd0);
      apb_read(5, v, e);
      chk("rsvd_slverr", 32'(e), 32'd1);
      apb_write(NUM_CH * 8 + 1, 'h10);

      // ch3 alone raises the interrupt
      apb_write(1, 'h00);
      apb_write(17, 'h00);
      apb_write(2, 'h00);
      apb_write(10, 'h00);
      apb_write(18, 'h00);
      apb_write(11, 'h00);
      apb_write(27, 'h01);
      apb_write(24, 'hFF);
      apb_write(25, 'h80);
      apb_write(25, 'h10);
      idle(6);
      chk("ch3_irq", 32'(o_irq), 32'h8);
      chk("ch3_irq_any", 32'(o_irq_any), 32'd1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         int a;
         int d;
         a = int'($urandom_range(0, 39));
         d = int'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) begin
            if ((a % 8) == 1 && $urandom_range(0, 3) != 0) d = d & 'h7F;
            apb_write(a, d);
         end else begin
            apb_read(a, v, e);
         end
         idle(int'($urandom_range(0, 3)));
      end

      // reset in the middle of counting
      apb_write(27, 'h01);
      apb_write(25, 'h10);
      idle(3);
      do_reset();
      check_all_zero();
      idle(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
